// File: rtl/mult_pipe.sv
// Pipelined fixed-point multiplier with valid/ready handshake, per-transaction sign select.
// Define MULT_SAT_EN to clamp overflowing results instead of wrapping.
module mult_pipe #(
  parameter int IN_WL     = 16,
  parameter int OUT_WL    = 16,
  parameter int FRAC_BITS = 0,
  parameter int STAGES    = 3
) (
  input  logic              clk,
  input  logic              rstb,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [IN_WL-1:0]  a,
  input  logic [IN_WL-1:0]  b,
  input  logic              sgn,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [OUT_WL-1:0] r,
  output logic              ovf
);

  localparam int PW = 2 * IN_WL;

`ifdef MULT_SAT_EN
  localparam logic [OUT_WL-1:0] ALL1 = {OUT_WL{1'b1}};
  localparam logic [OUT_WL-1:0] SMAX = ALL1 >> 1;
  localparam logic [OUT_WL-1:0] SMIN = ~SMAX;
`endif

  logic              en;
  logic              op_v;
  logic              op_sgn;
  logic [IN_WL-1:0]  op_a;
  logic [IN_WL-1:0]  op_b;
  logic [PW-1:0]     ext_a;
  logic [PW-1:0]     ext_b;
  logic [PW-1:0]     prod;
  logic [PW-1:0]     s_uns;
  logic [PW-1:0]     s;
  logic signed [PW-1:0] s_sgn;
  logic signed [PW-1:0] hi_sgn;
  logic              ovf_c;
  logic [OUT_WL-1:0] r_c;

  logic [STAGES:1]   v_q;
  logic [STAGES:1]   ovf_q;
  logic [OUT_WL-1:0] r_q [1:STAGES];

  assign en       = out_ready || !out_valid;
  assign in_ready = en;

  // Operands are registered on the accept edge; results then take STAGES more edges.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      op_v   <= 1'b0;
      op_sgn <= 1'b0;
      op_a   <= '0;
      op_b   <= '0;
    end else if (en) begin
      op_v   <= in_valid;
      op_sgn <= sgn;
      op_a   <= a;
      op_b   <= b;
    end
  end

  always_comb begin
    ext_a  = op_sgn ? {{IN_WL{op_a[IN_WL-1]}}, op_a} : {{IN_WL{1'b0}}, op_a};
    ext_b  = op_sgn ? {{IN_WL{op_b[IN_WL-1]}}, op_b} : {{IN_WL{1'b0}}, op_b};
    prod   = ext_a * ext_b;
    s_uns  = prod >> FRAC_BITS;
    s_sgn  = $signed(prod) >>> FRAC_BITS;
    s      = op_sgn ? $unsigned(s_sgn) : s_uns;
    // Signed fit means every bit from OUT_WL-1 upward equals the sign.
    hi_sgn = $signed(s) >>> (OUT_WL - 1);
    ovf_c  = op_sgn ? !((&hi_sgn) || (~|hi_sgn)) : (|(s >> OUT_WL));
    r_c    = s[OUT_WL-1:0];
`ifdef MULT_SAT_EN
    if (ovf_c) begin
      if (op_sgn) r_c = s[PW-1] ? SMIN : SMAX;
      else        r_c = ALL1;
    end
`endif
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      v_q   <= '0;
      ovf_q <= '0;
      for (int i = 1; i <= STAGES; i++) r_q[i] <= '0;
    end else if (en) begin
      v_q[1]   <= op_v;
      ovf_q[1] <= ovf_c;
      r_q[1]   <= r_c;
      for (int i = 2; i <= STAGES; i++) begin
        v_q[i]   <= v_q[i-1];
        ovf_q[i] <= ovf_q[i-1];
        r_q[i]   <= r_q[i-1];
      end
    end
  end

  assign out_valid = v_q[STAGES];
  assign ovf       = ovf_q[STAGES];
  assign r         = r_q[STAGES];

endmodule

// File: tb/tb_mult_pipe.sv
// Directed bench for mult_pipe: two 8-bit instances, integer (u0) and FRAC_BITS=4 (u1).
module tb_mult_pipe;

`ifdef MULT_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic clk = 1'b0;
  logic rstb = 1'b0;
  always #5 clk = ~clk;

  logic       in_valid = 1'b0;
  logic       sel = 1'b0;
  logic       sgn = 1'b0;
  logic       out_ready = 1'b1;
  logic       out_ready1 = 1'b1;
  logic [7:0] a = 8'h00;
  logic [7:0] b = 8'h00;

  logic       iv0, iv1, ir0, ir1, ov0, ov1, of0, of1;
  logic [7:0] r0, r1;
  logic       mv, mo, mir;
  logic [7:0] mr;

  assign iv0 = in_valid & ~sel;
  assign iv1 = in_valid & sel;
  assign mv  = sel ? ov1 : ov0;
  assign mo  = sel ? of1 : of0;
  assign mr  = sel ? r1 : r0;
  assign mir = sel ? ir1 : ir0;

  int errors = 0;
  int checks = 0;

  mult_pipe #(.IN_WL(8), .OUT_WL(8), .FRAC_BITS(0), .STAGES(3)) u0 (
    .clk(clk), .rstb(rstb), .in_valid(iv0), .in_ready(ir0), .a(a), .b(b), .sgn(sgn),
    .out_valid(ov0), .out_ready(out_ready), .r(r0), .ovf(of0)
  );

  mult_pipe #(.IN_WL(8), .OUT_WL(8), .FRAC_BITS(4), .STAGES(3)) u1 (
    .clk(clk), .rstb(rstb), .in_valid(iv1), .in_ready(ir1), .a(a), .b(b), .sgn(sgn),
    .out_valid(ov1), .out_ready(out_ready1), .r(r1), .ovf(of1)
  );

  logic       bp_s [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
  logic [7:0] bp_a [5] = '{8'hFD, 8'h0C, 8'hFF, 8'h10, 8'hF0};
  logic [7:0] bp_b [5] = '{8'h05, 8'h0A, 8'hFF, 8'h10, 8'h08};
  logic [7:0] bp_r [5] = '{8'hF1, 8'h78, 8'h01, (SAT ? 8'hFF : 8'h00), 8'h80};
  logic       bp_o [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

  logic       bb_s [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
  logic [7:0] bb_a [4] = '{8'h03, 8'hFF, 8'hFF, 8'h7F};
  logic [7:0] bb_b [4] = '{8'h04, 8'h02, 8'h01, 8'h01};
  logic [7:0] bb_r [4] = '{8'h0C, 8'hFE, 8'hFF, 8'h7F};

  task automatic run_single(input logic inst, input logic s, input logic [7:0] va,
                            input logic [7:0] vb, input logic [7:0] er, input logic eo,
                            input string name);
    int lat;
    @(negedge clk);
    sel = inst; sgn = s; a = va; b = vb; in_valid = 1'b1; out_ready = 1'b1;
    #1;
    checks++;
    if (mir !== 1'b1) begin
      errors++; $display("FAIL %s in_ready got %b want 1", name, mir);
    end
    @(negedge clk);
    in_valid = 1'b0;
    lat = 0;
    while (mv !== 1'b1 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    checks++;
    if (lat !== 3) begin
      errors++; $display("FAIL %s latency got %0d want 3", name, lat);
    end
    checks++;
    if (mr !== er || mo !== eo) begin
      errors++; $display("FAIL %s r/ovf got %h/%b want %h/%b", name, mr, mo, er, eo);
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    #12;
    checks++;
    if (ov0 !== 1'b0 || r0 !== 8'h00 || of0 !== 1'b0 || ir0 !== 1'b1 || ov1 !== 1'b0) begin
      errors++;
      $display("FAIL reset_state got v=%b r=%h o=%b rdy=%b v1=%b want 0 00 0 1 0", ov0, r0, of0, ir0, ov1);
    end
    @(negedge clk);
    rstb = 1'b1;
  endtask

  task automatic test_unsigned();
    run_single(1'b0, 1'b0, 8'd12, 8'd10, 8'd120, 1'b0, "unsigned_12x10");
    run_single(1'b0, 1'b0, 8'hFF, 8'h01, 8'hFF, 1'b0, "unsigned_max_fit");
  endtask

  task automatic test_signed();
    run_single(1'b0, 1'b1, 8'hFD, 8'h05, 8'hF1, 1'b0, "signed_m3x5");
    run_single(1'b0, 1'b1, 8'hFF, 8'hFF, 8'h01, 1'b0, "signed_m1xm1");
    run_single(1'b0, 1'b1, 8'hF0, 8'h08, 8'h80, 1'b0, "signed_min_fit");
  endtask

  task automatic test_overflow();
    run_single(1'b0, 1'b0, 8'h10, 8'h10, (SAT ? 8'hFF : 8'h00), 1'b1, "ovf_unsigned_16x16");
    run_single(1'b0, 1'b1, 8'h80, 8'h80, (SAT ? 8'h7F : 8'h00), 1'b1, "ovf_signed_m128sq");
    run_single(1'b0, 1'b1, 8'h40, 8'h04, (SAT ? 8'h7F : 8'h00), 1'b1, "ovf_signed_pos");
    run_single(1'b0, 1'b1, 8'hC0, 8'h04, (SAT ? 8'h80 : 8'h00), 1'b1, "ovf_signed_neg");
    run_single(1'b0, 1'b0, 8'hFD, 8'h05, (SAT ? 8'hFF : 8'hF1), 1'b1, "ovf_unsigned_253x5");
  endtask

  task automatic test_frac();
    run_single(1'b1, 1'b0, 8'h18, 8'h28, 8'h3C, 1'b0, "frac_1p5x2p5");
    run_single(1'b1, 1'b1, 8'hE8, 8'h28, 8'hC4, 1'b0, "frac_m1p5x2p5");
    run_single(1'b1, 1'b1, 8'hFF, 8'h01, 8'hFF, 1'b0, "frac_floor_neg");
    run_single(1'b1, 1'b0, 8'hFF, 8'hFF, (SAT ? 8'hFF : 8'hE0), 1'b1, "frac_ovf_unsigned");
  endtask

  task automatic test_back_to_back();
    sel = 1'b0; out_ready = 1'b1;
    for (int i = 0; i <= 8; i++) begin
      @(negedge clk);
      if (i == 3 || i == 8) begin
        checks++;
        if (ov0 !== 1'b0) begin
          errors++; $display("FAIL b2b_idle_%0d out_valid got %b want 0", i, ov0);
        end
      end
      if (i >= 4 && i < 8) begin
        checks++;
        if (ov0 !== 1'b1 || r0 !== bb_r[i-4] || of0 !== 1'b0) begin
          errors++;
          $display("FAIL b2b_%0d v/r/ovf got %b/%h/%b want 1/%h/0", i-4, ov0, r0, of0, bb_r[i-4]);
        end
      end
      if (i < 4) begin
        in_valid = 1'b1; sgn = bb_s[i]; a = bb_a[i]; b = bb_b[i];
      end else begin
        in_valid = 1'b0;
      end
    end
  endtask

  task automatic test_backpressure();
    int   nin = 0;
    int   nout = 0;
    int   stall_left = 0;
    int   cyc = 0;
    logic seen = 1'b0;
    logic bubble_done = 1'b0;
    logic prev_stall = 1'b0;
    logic [7:0] held_r = 8'h00;
    logic held_o = 1'b0;
    sel = 1'b0;
    while (nout < 5 && cyc < 80) begin
      @(negedge clk);
      cyc++;
      if (prev_stall) begin
        checks++;
        if (ov0 !== 1'b1 || r0 !== held_r || of0 !== held_o) begin
          errors++;
          $display("FAIL bp_hold got %b/%h/%b want 1/%h/%b", ov0, r0, of0, held_r, held_o);
        end
      end
      if (ov0 === 1'b1 && !seen) begin
        seen = 1'b1; stall_left = 4;
      end
      out_ready = (stall_left == 0);
      if (stall_left > 0) stall_left--;
      if (nin < 5) begin
        if (nin == 2 && !bubble_done) begin
          in_valid = 1'b0; bubble_done = 1'b1;
        end else begin
          in_valid = 1'b1; sgn = bp_s[nin]; a = bp_a[nin]; b = bp_b[nin];
        end
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (!out_ready) begin
        checks++;
        if (ir0 !== 1'b0) begin
          errors++; $display("FAIL bp_in_ready got %b want 0", ir0);
        end
      end
      if (in_valid && ir0 === 1'b1) nin++;
      if (ov0 === 1'b1 && out_ready) begin
        checks++;
        if (r0 !== bp_r[nout] || of0 !== bp_o[nout]) begin
          errors++;
          $display("FAIL bp_result_%0d got %h/%b want %h/%b", nout, r0, of0, bp_r[nout], bp_o[nout]);
        end
        nout++;
      end
      prev_stall = (ov0 === 1'b1) && !out_ready;
      held_r = r0; held_o = of0;
    end
    checks++;
    if (nout !== 5) begin
      errors++; $display("FAIL bp_count got %0d want 5", nout);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (ov0 !== 1'b0) begin
      errors++; $display("FAIL bp_no_dup out_valid got %b want 0", ov0);
    end
  endtask

  task automatic test_reset_midflight();
    int   wait_cyc = 0;
    logic leak = 1'b0;
    sel = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b1; sgn = 1'b0; a = 8'h10; b = 8'h10;
    @(negedge clk);
    sgn = 1'b1; a = 8'hFD; b = 8'h05;
    @(negedge clk);
    in_valid = 1'b0;
    while (ov0 !== 1'b1 && wait_cyc < 20) begin
      @(negedge clk);
      wait_cyc++;
    end
    out_ready = 1'b0;
    checks++;
    if (ov0 !== 1'b1 || r0 !== (SAT ? 8'hFF : 8'h00) || of0 !== 1'b1) begin
      errors++;
      $display("FAIL rst_pre got %b/%h/%b want 1/%h/1", ov0, r0, of0, (SAT ? 8'hFF : 8'h00));
    end
    #2 rstb = 1'b0;
    #1;
    checks++;
    if (ov0 !== 1'b0 || r0 !== 8'h00 || of0 !== 1'b0 || ir0 !== 1'b1) begin
      errors++;
      $display("FAIL rst_async got v=%b r=%h o=%b rdy=%b want 0 00 0 1", ov0, r0, of0, ir0);
    end
    #1 rstb = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (ov0 !== 1'b0) leak = 1'b1;
    end
    checks++;
    if (leak !== 1'b0) begin
      errors++; $display("FAIL rst_no_stale got leak=%b want 0", leak);
    end
    run_single(1'b0, 1'b0, 8'd12, 8'd10, 8'd120, 1'b0, "post_reset");
  endtask

  initial begin
    test_reset();
    test_unsigned();
    test_signed();
    test_overflow();
    test_frac();
    test_back_to_back();
    test_backpressure();
    test_reset_midflight();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end

endmodule
